// File: rtl/alu_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_master
// Description : Accepts one ALU command at a time, drives the ALU enable,
//               opcode and operand buses, waits ALU_LAT cycles, captures the
//               result and interrupt flag, clears the ALU interrupt when it
//               was raised, and presents the response on a valid/ready port.
//               Keeps a saturating count of interrupting responses.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_master #(
  parameter int DATA_W  = 8,
  parameter int OP_W    = 3,
  parameter int ALU_LAT = 1
) (
  input  logic              alu_clk,
  input  logic              rst,
  // command port
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_mode,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  // ALU side
  output logic              alu_enable,
  output logic              alu_enable_a,
  output logic              alu_enable_b,
  output logic [OP_W-1:0]   alu_op_a,
  output logic [OP_W-1:0]   alu_op_b,
  output logic [DATA_W-1:0] alu_in_a,
  output logic [DATA_W-1:0] alu_in_b,
  output logic              alu_irq_clr,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_irq,
  // response port
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_irq,
  output logic [7:0]        irq_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_WAIT   = 3'd2,
    S_IRQCLR = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  // WAIT lasts ALU_LAT cycles; the counter runs down to zero on the last one.
  localparam logic [3:0] LAT_LAST = 4'(ALU_LAT - 1);

  state_t              state_q,        state_d;
  logic [3:0]          cnt_q,          cnt_d;
  logic                cmd_ready_q,    cmd_ready_d;
  logic                alu_enable_q,   alu_enable_d;
  logic                alu_enable_a_q, alu_enable_a_d;
  logic                alu_enable_b_q, alu_enable_b_d;
  logic [OP_W-1:0]     alu_op_a_q,     alu_op_a_d;
  logic [OP_W-1:0]     alu_op_b_q,     alu_op_b_d;
  logic [DATA_W-1:0]   alu_in_a_q,     alu_in_a_d;
  logic [DATA_W-1:0]   alu_in_b_q,     alu_in_b_d;
  logic                alu_irq_clr_q,  alu_irq_clr_d;
  logic                rsp_valid_q,    rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q,     rsp_data_d;
  logic                rsp_irq_q,      rsp_irq_d;
  logic [7:0]          irq_cnt_q,      irq_cnt_d;

  // Next-state and registered-output computation; outputs are prepared one
  // cycle ahead so they are valid for the whole cycle of the state they belong to.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    cmd_ready_d    = cmd_ready_q;
    alu_enable_d   = 1'b0;
    alu_enable_a_d = 1'b0;
    alu_enable_b_d = 1'b0;
    alu_op_a_d     = alu_op_a_q;
    alu_op_b_d     = alu_op_b_q;
    alu_in_a_d     = alu_in_a_q;
    alu_in_b_d     = alu_in_b_q;
    alu_irq_clr_d  = 1'b0;
    rsp_valid_d    = rsp_valid_q;
    rsp_data_d     = rsp_data_q;
    rsp_irq_d      = rsp_irq_q;
    irq_cnt_d      = irq_cnt_q;

    case (state_q)
      S_IDLE: begin
        // cmd_ready rises on the first edge after reset release
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          state_d        = S_DRIVE;
          cmd_ready_d    = 1'b0;
          alu_enable_d   = 1'b1;
          alu_enable_a_d = ~cmd_mode;
          alu_enable_b_d = cmd_mode;
          alu_op_a_d     = cmd_mode ? '0 : cmd_op;
          alu_op_b_d     = cmd_mode ? cmd_op : '0;
          alu_in_a_d     = cmd_a;
          alu_in_b_d     = cmd_b;
        end
      end
      S_DRIVE: begin
        cnt_d   = LAT_LAST;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          // alu_irq is only looked at here; earlier wiggles are ignored
          rsp_data_d = alu_out;
          rsp_irq_d  = alu_irq;
          if (alu_irq) begin
            state_d       = S_IRQCLR;
            alu_irq_clr_d = 1'b1;
          end else begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_IRQCLR: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          if (rsp_irq_q && (irq_cnt_q != 8'hFF)) begin
            irq_cnt_d = irq_cnt_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight command.
  always_ff @(posedge alu_clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= 4'd0;
      cmd_ready_q    <= 1'b0;
      alu_enable_q   <= 1'b0;
      alu_enable_a_q <= 1'b0;
      alu_enable_b_q <= 1'b0;
      alu_op_a_q     <= '0;
      alu_op_b_q     <= '0;
      alu_in_a_q     <= '0;
      alu_in_b_q     <= '0;
      alu_irq_clr_q  <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      rsp_irq_q      <= 1'b0;
      irq_cnt_q      <= 8'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cmd_ready_q    <= cmd_ready_d;
      alu_enable_q   <= alu_enable_d;
      alu_enable_a_q <= alu_enable_a_d;
      alu_enable_b_q <= alu_enable_b_d;
      alu_op_a_q     <= alu_op_a_d;
      alu_op_b_q     <= alu_op_b_d;
      alu_in_a_q     <= alu_in_a_d;
      alu_in_b_q     <= alu_in_b_d;
      alu_irq_clr_q  <= alu_irq_clr_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      rsp_irq_q      <= rsp_irq_d;
      irq_cnt_q      <= irq_cnt_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign alu_enable   = alu_enable_q;
  assign alu_enable_a = alu_enable_a_q;
  assign alu_enable_b = alu_enable_b_q;
  assign alu_op_a     = alu_op_a_q;
  assign alu_op_b     = alu_op_b_q;
  assign alu_in_a     = alu_in_a_q;
  assign alu_in_b     = alu_in_b_q;
  assign alu_irq_clr  = alu_irq_clr_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_irq      = rsp_irq_q;
  assign irq_cnt      = irq_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_cmd_master
// Description : Self-checking bench for alu_cmd_master. Two instances run
//               side by side (ALU_LAT=1 and ALU_LAT=4). A behavioural ALU
//               returns the scripted result exactly ALU_LAT cycles after the
//               enable and toggles its interrupt line at all other times.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_master;

  logic clk = 1'b0;
  logic rst;

  logic       cmd_valid [2];
  logic       cmd_ready [2];
  logic       cmd_mode  [2];
  logic [2:0] cmd_op    [2];
  logic [7:0] cmd_a     [2];
  logic [7:0] cmd_b     [2];
  logic       alu_enable   [2];
  logic       alu_enable_a [2];
  logic       alu_enable_b [2];
  logic [2:0] alu_op_a  [2];
  logic [2:0] alu_op_b  [2];
  logic [7:0] alu_in_a  [2];
  logic [7:0] alu_in_b  [2];
  logic       alu_irq_clr [2];
  logic [7:0] alu_out   [2];
  logic       alu_irq   [2];
  logic       rsp_valid [2];
  logic       rsp_ready [2];
  logic [7:0] rsp_data  [2];
  logic       rsp_irq   [2];
  logic [7:0] irq_cnt   [2];

  // scripted ALU answer for the command in flight on each instance
  logic [7:0] alu_res_v [2];
  logic       alu_irq_v [2];

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt [2];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    alu_cmd_master #(
      .DATA_W (8),
      .OP_W   (3),
      .ALU_LAT((gi == 0) ? 1 : 4)
    ) u_dut (
      .alu_clk     (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid[gi]),
      .cmd_ready   (cmd_ready[gi]),
      .cmd_mode    (cmd_mode[gi]),
      .cmd_op      (cmd_op[gi]),
      .cmd_a       (cmd_a[gi]),
      .cmd_b       (cmd_b[gi]),
      .alu_enable  (alu_enable[gi]),
      .alu_enable_a(alu_enable_a[gi]),
      .alu_enable_b(alu_enable_b[gi]),
      .alu_op_a    (alu_op_a[gi]),
      .alu_op_b    (alu_op_b[gi]),
      .alu_in_a    (alu_in_a[gi]),
      .alu_in_b    (alu_in_b[gi]),
      .alu_irq_clr (alu_irq_clr[gi]),
      .alu_out     (alu_out[gi]),
      .alu_irq     (alu_irq[gi]),
      .rsp_valid   (rsp_valid[gi]),
      .rsp_ready   (rsp_ready[gi]),
      .rsp_data    (rsp_data[gi]),
      .rsp_irq     (rsp_irq[gi]),
      .irq_cnt     (irq_cnt[gi])
    );
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  // Behavioural ALU: cycle k after the enable cycle (k=0) it shows the real
  // answer when k == ALU_LAT, otherwise random data and a toggling irq.
  int k_cnt [2];
  always @(negedge clk) begin
    int k;
    for (int d = 0; d < 2; d++) begin
      if (alu_enable[d] === 1'b1) k = 0;
      else if (k_cnt[d] < 100)    k = k_cnt[d] + 1;
      else                        k = k_cnt[d];
      k_cnt[d] <= k;
      if (k == lat_of(d)) begin
        alu_out[d] <= alu_res_v[d];
        alu_irq[d] <= alu_irq_v[d];
      end else begin
        alu_out[d] <= 8'($urandom);
        alu_irq[d] <= ~alu_irq[d];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs(input int d);
    return {19'd0, cmd_ready[d], alu_enable[d], alu_enable_a[d], alu_enable_b[d],
            alu_op_a[d], alu_op_b[d], alu_in_a[d], alu_in_b[d], alu_irq_clr[d],
            rsp_valid[d], rsp_data[d], rsp_irq[d], irq_cnt[d]};
  endfunction

  // One full command: offer, check DRIVE, watch WAIT/IRQCLR, check the
  // response, optionally stall rsp_ready, then complete the handshake.
  task automatic run_cmd(input int d, input logic mode, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] res, input logic irq, input int rdy_wait,
                         input int exp_lat, input logic [7:0] exp_data,
                         input logic exp_irq, input string tag);
    int t;
    int clr_cnt;
    int clr_at;
    bit hold_ok;
    bit busy_ok;
    bit stable_ok;
    t = 0;
    while (cmd_ready[d] !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("%s cmd_ready", tag), 64'(cmd_ready[d]), 64'd1);
    if (cmd_ready[d] !== 1'b1) return;
    cmd_valid[d] = 1'b1; cmd_mode[d] = mode; cmd_op[d] = op;
    cmd_a[d] = a; cmd_b[d] = b;
    alu_res_v[d] = res; alu_irq_v[d] = irq;
    @(negedge clk);
    cmd_valid[d] = 1'b0;
    check($sformatf("%s drive_en", tag),
          64'({alu_enable[d], alu_enable_a[d], alu_enable_b[d]}), 64'({1'b1, ~mode, mode}));
    check($sformatf("%s drive_ops", tag), 64'({alu_op_a[d], alu_op_b[d]}),
          64'({(mode ? 3'd0 : op), (mode ? op : 3'd0)}));
    check($sformatf("%s drive_in", tag), 64'({alu_in_a[d], alu_in_b[d]}), 64'({a, b}));

    t = 1; clr_cnt = 0; clr_at = 0; hold_ok = 1'b1; busy_ok = 1'b1;
    while (rsp_valid[d] !== 1'b1 && t < 40) begin
      // junk offers and early ready pulses must both be ignored here
      cmd_valid[d] = 1'($urandom_range(0, 1));
      cmd_a[d] = 8'($urandom); cmd_b[d] = 8'($urandom); cmd_op[d] = 3'($urandom);
      rsp_ready[d] = 1'($urandom_range(0, 1));
      @(negedge clk);
      t++;
      if (alu_irq_clr[d] === 1'b1) begin clr_cnt++; clr_at = t; end
      if (cmd_ready[d] !== 1'b0) busy_ok = 1'b0;
      if (rsp_valid[d] !== 1'b1) begin
        if ({alu_enable[d], alu_enable_a[d], alu_enable_b[d]} !== 3'b000 ||
            alu_in_a[d] !== a || alu_in_b[d] !== b ||
            alu_op_a[d] !== (mode ? 3'd0 : op) || alu_op_b[d] !== (mode ? op : 3'd0))
          hold_ok = 1'b0;
      end
    end
    cmd_valid[d] = 1'b0;
    rsp_ready[d] = 1'b0;
    check($sformatf("%s latency", tag), 64'(t), 64'(exp_lat));
    check($sformatf("%s wait_hold", tag), 64'(hold_ok), 64'd1);
    check($sformatf("%s busy", tag), 64'(busy_ok), 64'd1);
    check($sformatf("%s irq_clr_pulses", tag), 64'(clr_cnt), 64'(exp_irq ? 1 : 0));
    if (exp_irq) check($sformatf("%s irq_clr_pos", tag), 64'(clr_at), 64'(t - 1));
    if (rsp_valid[d] !== 1'b1) return;
    check($sformatf("%s rsp_data", tag), 64'(rsp_data[d]), 64'(exp_data));
    check($sformatf("%s rsp_irq", tag), 64'(rsp_irq[d]), 64'(exp_irq));

    stable_ok = 1'b1;
    for (int i = 0; i < rdy_wait; i++) begin
      @(negedge clk);
      if (rsp_valid[d] !== 1'b1 || rsp_data[d] !== exp_data || rsp_irq[d] !== exp_irq ||
          cmd_ready[d] !== 1'b0 || alu_irq_clr[d] !== 1'b0)
        stable_ok = 1'b0;
    end
    if (rdy_wait > 0) check($sformatf("%s resp_stall", tag), 64'(stable_ok), 64'd1);

    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    if (exp_irq && exp_cnt[d] < 255) exp_cnt[d]++;
    check($sformatf("%s post_valid", tag), 64'(rsp_valid[d]), 64'd0);
    check($sformatf("%s post_ready", tag), 64'(cmd_ready[d]), 64'd1);
    check($sformatf("%s irq_cnt", tag), 64'(irq_cnt[d]), 64'(exp_cnt[d]));
  endtask

  typedef struct {
    logic       mode;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       irq;
    int         rdy_wait;
    int         exp_lat;
    logic [7:0] exp_data;
    logic       exp_irq;
  } vec_t;

  vec_t tbl [5];

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit no_rsp;
    // directed vectors on the ALU_LAT=1 instance
    tbl[0] = '{1'b0, 3'd0, 8'h12, 8'h34, 8'h46, 1'b0, 0, 3, 8'h46, 1'b0};
    tbl[1] = '{1'b1, 3'd2, 8'h0F, 8'hF0, 8'hFF, 1'b1, 0, 4, 8'hFF, 1'b1};
    tbl[2] = '{1'b0, 3'd5, 8'hA5, 8'h5A, 8'h3C, 1'b0, 5, 3, 8'h3C, 1'b0};
    tbl[3] = '{1'b1, 3'd7, 8'hFF, 8'h01, 8'h00, 1'b1, 2, 4, 8'h00, 1'b1};
    tbl[4] = '{1'b0, 3'd7, 8'h00, 8'h00, 8'h80, 1'b1, 0, 4, 8'h80, 1'b1};

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      cmd_valid[d] = 1'b0; cmd_mode[d] = 1'b0; cmd_op[d] = 3'd0;
      cmd_a[d] = 8'd0; cmd_b[d] = 8'd0; rsp_ready[d] = 1'b0;
      alu_res_v[d] = 8'd0; alu_irq_v[d] = 1'b0; exp_cnt[d] = 0;
      k_cnt[d] = 100; alu_irq[d] = 1'b0; alu_out[d] = 8'd0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) check($sformatf("reset_outs%0d", d), outs(d), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) check($sformatf("release_ready%0d", d), 64'(cmd_ready[d]), 64'd1);

    for (int i = 0; i < 5; i++) begin
      run_cmd(0, tbl[i].mode, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].irq,
              tbl[i].rdy_wait, tbl[i].exp_lat, tbl[i].exp_data, tbl[i].exp_irq,
              $sformatf("tbl%0d", i));
    end

    // long latency with irq toggling outside the capture cycle
    run_cmd(1, 1'b0, 3'd3, 8'h21, 8'h43, 8'h5E, 1'b0, 0, 6, 8'h5E, 1'b0, "lat4");

    // randomized commands against the scripted-ALU model
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 25; i++) begin
        logic       m;
        logic [2:0] o;
        logic [7:0] a, b, r;
        logic       q;
        m = 1'($urandom_range(0, 1)); o = 3'($urandom);
        a = 8'($urandom); b = 8'($urandom); r = 8'($urandom);
        q = 1'($urandom_range(0, 1));
        run_cmd(d, m, o, a, b, r, q, int'($urandom_range(0, 3)), lat_of(d) + 2 + int'(q),
                r, q, $sformatf("rnd%0d_%0d", d, i));
      end
    end

    // reset in the middle of WAIT on the ALU_LAT=4 instance
    while (cmd_ready[1] !== 1'b1) @(negedge clk);
    cmd_valid[1] = 1'b1; cmd_mode[1] = 1'b1; cmd_op[1] = 3'd4;
    cmd_a[1] = 8'h77; cmd_b[1] = 8'h88; alu_res_v[1] = 8'h99; alu_irq_v[1] = 1'b1;
    @(negedge clk);
    cmd_valid[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) check($sformatf("midreset_outs%0d", d), outs(d), 64'd0);
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midreset_ready", 64'(cmd_ready[1]), 64'd1);
    no_rsp = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid[1] !== 1'b0 || alu_irq_clr[1] !== 1'b0) no_rsp = 1'b0;
    end
    check("midreset_no_rsp", 64'(no_rsp), 64'd1);
    run_cmd(1, 1'b0, 3'd1, 8'h10, 8'h01, 8'h0F, 1'b0, 1, 6, 8'h0F, 1'b0, "after_reset");

    // irq counter saturation
    for (int i = 0; i < 260; i++) begin
      run_cmd(0, 1'b1, 3'd1, 8'(i), 8'(~i), 8'hC3, 1'b1, 0, 4, 8'hC3, 1'b1,
              $sformatf("sat%0d", i));
    end
    check("irq_cnt_saturated", 64'(irq_cnt[0]), 64'd255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
